// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and lane helpers for the wait-state data memory.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size encoding 3 falls into the default arm and behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wdata,
                                              input logic [1:0]  size);
    case (size)
      SZ_BYTE: store_align = {4{wdata[7:0]}};
      SZ_HALF: store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = |addr_lo;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  addr_lo,
                                               input logic        sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sign_ext & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ram
// Purpose : Single-port word RAM with per-byte write enables, synchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int WORD_AW     = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [3:0]         be,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read-first: a same-edge write is not visible on rdata until the next read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_wait_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmem_wait_unit
// Purpose : Byte/half/word data memory behind a req/done handshake with
//           WAIT_CYCLES wait states and a datapath stall. Defining
//           DMEM_ALIGN_CHK_EN adds misaligned-access suppression and err.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_wait_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall
`ifdef DMEM_ALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int c_word_aw = $clog2(DEPTH_WORDS);
  localparam int c_cnt_w   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [c_word_aw-1:0] w_word_idx;
  logic [3:0]           w_be;
  logic [31:0]          w_store_data;
  logic [31:0]          w_ram_word;
  logic                 w_access;
  logic                 w_misalign;

  assign w_word_idx   = addr[c_word_aw+1:2];
  assign w_store_data = store_align(wdata, size);

  // Upper address bits are deliberately dropped so accesses wrap.
  generate
    if (ADDR_W > c_word_aw + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:c_word_aw+2];
    end
  endgenerate

`ifdef DMEM_ALIGN_CHK_EN
  logic err_q, err_d;
  assign w_misalign = misaligned(size, addr[1:0]);
  assign err_d      = done_d & w_misalign;
  assign err        = err_q;
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    w_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = c_cnt_load;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end else begin
          w_access = 1'b1;
          done_d   = 1'b1;
          state_d  = DONE;
          if (!we && !w_misalign) begin
            rdata_d = load_extract(w_ram_word, size, addr[1:0], sign_ext);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset on the access edge must also cancel the RAM write.
  assign w_be = (w_access && we && !w_misalign && !reset) ? lane_mask(size, addr[1:0])
                                                          : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // The RAM reads continuously while req is held, so its registered word is
  // already current by the access edge even with zero wait cycles.
  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WORD_AW     (c_word_aw)
  ) u_ram (
    .clk   (clk),
    .rd_en (req),
    .be    (w_be),
    .addr  (w_word_idx),
    .wdata (w_store_data),
    .rdata (w_ram_word)
  );

  assign rdata = rdata_q;
  assign done  = done_q;
  assign stall = req & ~done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_wait_unit
// Purpose : Scoreboard bench for dmem_wait_unit at WAIT_CYCLES=2 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_wait_unit;
  import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHK_EN
  localparam logic        c_chk      = 1'b1;
  localparam logic [31:0] c_w10_fin  = 32'hBEEFAB78;
  localparam logic [31:0] c_lh12     = 32'hFFFFBEEF;
  localparam logic [31:0] c_lbu13    = 32'h000000BE;
`else
  localparam logic        c_chk      = 1'b0;
  localparam logic [31:0] c_w10_fin  = 32'hDEADBEEF;
  localparam logic [31:0] c_lh12     = 32'hFFFFDEAD;
  localparam logic [31:0] c_lbu13    = 32'h000000DE;
`endif

  logic        clk = 1'b0;
  logic        reset2, reset3, req2, req3, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata2, rdata3;
  logic        done2, done3, stall2, stall3;
`ifdef DMEM_ALIGN_CHK_EN
  logic        err2, err3;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t m2, m3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_wait_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .reset(reset2), .req(req2), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .done(done2), .stall(stall2)
`ifdef DMEM_ALIGN_CHK_EN
    , .err(err2)
`endif
  );

  dmem_wait_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .reset(reset3), .req(req3), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .done(done3), .stall(stall3)
`ifdef DMEM_ALIGN_CHK_EN
    , .err(err3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input int d);
    return (d == 2) ? done2 : done3;
  endfunction

  function automatic logic cur_stall(input int d);
    return (d == 2) ? stall2 : stall3;
  endfunction

  // Monitors: pop the expected response whenever a unit pulses done.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        check("dut2 unexpected done", 32'd1, 32'd0);
      end else begin
        m2 = q2.pop_front();
        check("dut2 rdata", rdata2, m2.rdata);
`ifdef DMEM_ALIGN_CHK_EN
        check("dut2 err", {31'd0, err2}, {31'd0, m2.err});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        check("dut3 unexpected done", 32'd1, 32'd0);
      end else begin
        m3 = q3.pop_front();
        check("dut3 rdata", rdata3, m3.rdata);
`ifdef DMEM_ALIGN_CHK_EN
        check("dut3 err", {31'd0, err3}, {31'd0, m3.err});
`endif
      end
    end
  end

  // req must stay high while a unit is waiting.
  always @(posedge clk) begin
    if (!reset2 && u_dut2.state_q == BUSY && !req2) begin
      errors++;
      $display("FAIL protocol dut2: req dropped in BUSY");
    end
    if (!reset3 && u_dut3.state_q == BUSY && !req3) begin
      errors++;
      $display("FAIL protocol dut3: req dropped in BUSY");
    end
  end

  task automatic do_op(input int d, input logic w, input logic [1:0] sz,
                       input logic se, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    int   k;
    int   lat;
    logic stall_ok;
    logic got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    lat     = (d == 2) ? 4 : 5;
    if (d == 2) q2.push_back(e);
    else        q3.push_back(e);
    we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    if (d == 2) req2 = 1'b1;
    else        req3 = 1'b1;
    k = 0; stall_ok = 1'b1; got = 1'b0;
    while (k < 50 && !got) begin
      @(negedge clk);
      k++;
      if (cur_done(d)) got = 1'b1;
      else if (!cur_stall(d)) stall_ok = 1'b0;
    end
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " latency"}, k, lat);
      check({name, " stall while waiting"}, {31'd0, stall_ok}, 32'd1);
      check({name, " stall on done"}, {31'd0, cur_stall(d)}, 32'd0);
    end
    req2 = 1'b0;
    req3 = 1'b0;
    @(negedge clk);
    check({name, " done pulse width"}, {31'd0, cur_done(d)}, 32'd0);
  endtask

  initial begin
    logic seen;
    reset2 = 1'b1; reset3 = 1'b1; req2 = 1'b0; req3 = 1'b0;
    we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset2 = 1'b0; reset3 = 1'b0;
    @(negedge clk);
    check("reset rdata2", rdata2, 32'h0);
    check("reset done2", {31'd0, done2}, 32'd0);
    check("reset stall2", {31'd0, stall2}, 32'd0);
    check("reset rdata3", rdata3, 32'h0);

    do_op(2, 1'b1, SZ_WORD, 1'b0, 32'h10,  32'h12345678, 32'h00000000, 1'b0,  "sw 0x10");
    do_op(2, 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0,  "lw 0x10");
    do_op(2, 1'b1, SZ_BYTE, 1'b0, 32'h11,  32'h000000AB, 32'h12345678, 1'b0,  "sb 0x11");
    do_op(2, 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h1234AB78, 1'b0,  "lw after sb");
    do_op(2, 1'b0, SZ_BYTE, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAB, 1'b0,  "lb 0x11");
    do_op(2, 1'b0, SZ_BYTE, 1'b0, 32'h11,  32'h0,        32'h000000AB, 1'b0,  "lbu 0x11");
    do_op(2, 1'b1, SZ_HALF, 1'b0, 32'h12,  32'h0000BEEF, 32'h000000AB, 1'b0,  "sh 0x12");
    do_op(2, 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hBEEFAB78, 1'b0,  "lw after sh");
    do_op(2, 1'b0, SZ_HALF, 1'b0, 32'h12,  32'h0,        32'h0000BEEF, 1'b0,  "lhu 0x12");
    do_op(2, 1'b1, SZ_WORD, 1'b0, 32'h13,  32'hDEADBEEF, 32'h0000BEEF, c_chk, "sw 0x13");
    do_op(2, 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        c_w10_fin,    1'b0,  "lw after misaligned sw");
    do_op(2, 1'b0, SZ_HALF, 1'b1, 32'h12,  32'h0,        c_lh12,       1'b0,  "lh 0x12");
    do_op(2, 1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        c_lbu13,      1'b0,  "lbu 0x13");
    do_op(2, 1'b0, 2'd3,    1'b1, 32'h110, 32'h0,        c_w10_fin,    1'b0,  "lw size3 wrapped");

    do_op(3, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 32'h00000000, 1'b0, "w3 sw 0x20");
    do_op(3, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, "w3 lw 0x20");

    // Store aborted by reset during the second wait cycle.
    we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h11111111;
    req3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset3 = 1'b1;
    req3   = 1'b0;
    @(negedge clk);
    reset3 = 1'b0;
    check("abort state idle", {30'd0, u_dut3.state_q}, {30'd0, IDLE});
    check("abort rdata reset", rdata3, 32'h0);
    seen = done3;
    repeat (6) begin
      @(negedge clk);
      if (done3) seen = 1'b1;
    end
    check("abort no done", {31'd0, seen}, 32'd0);

    do_op(3, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "w3 lw after abort");

    check("dut2 scoreboard drained", q2.size(), 32'd0);
    check("dut3 scoreboard drained", q3.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
